// File: rtl/prog_loader.sv
// Boot-time program loader: parses a header + (low, high) byte-pair stream into
// IW-bit words, writes them to instruction memory, and stalls the core until done.
module prog_loader #(
  parameter int IW = 9,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          core_hold,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  localparam int CW    = AW + 1;
  localparam int DEPTH = 2 ** AW;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; the
  // sender holds in_data stable until then, and in_ready depends on state only.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LO,
    S_HI,
    S_WR,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_q, n_d;
  logic [7:0]    low_q, low_d;
  logic          bit8_q, bit8_d;
  logic          xfer;
  logic [CW-1:0] count_inc;

  assign xfer      = in_valid && in_ready;
  assign count_inc = count_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      n_q     <= '0;
      low_q   <= '0;
      bit8_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      n_q     <= n_d;
      low_q   <= low_d;
      bit8_q  <= bit8_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    n_d     = n_q;
    low_d   = low_q;
    bit8_d  = bit8_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          count_d = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          // N is checked here so the write address can never wrap.
          if (in_data == 8'd0 || 32'(in_data) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            n_d     = CW'(in_data);
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (xfer) begin
          low_d   = in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          if (in_data[7:1] != 7'd0) begin
            state_d = S_ERR;
          end else begin
            bit8_d  = in_data[0];
            state_d = S_WR;
          end
        end
      end
      S_WR: begin
        count_d = count_inc;
        state_d = (count_inc == n_q) ? S_DONE : S_LO;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready   = (state_q == S_HDR) || (state_q == S_LO) || (state_q == S_HI);
  assign imem_we    = (state_q == S_WR);
  assign imem_addr  = count_q[AW-1:0];
  assign imem_wdata = IW'({bit8_q, low_q});
  assign core_hold  = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign count      = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default build (AW=8) plus a small AW=2 build,
// with a write scoreboard fed from the instruction-memory port.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, sel;
  logic [7:0] in_data;

  logic       b_in_ready, b_we, b_hold, b_done, b_err;
  logic [7:0] b_addr;
  logic [8:0] b_wdata, b_count;
  logic       s_in_ready, s_we, s_hold, s_done, s_err;
  logic [1:0] s_addr;
  logic [8:0] s_wdata;
  logic [2:0] s_count;

  logic b_start, b_valid, s_start, s_valid;
  assign b_start = start & ~sel;
  assign b_valid = in_valid & ~sel;
  assign s_start = start & sel;
  assign s_valid = in_valid & sel;

  logic       m_ready, m_we, m_hold, m_done, m_err;
  logic [7:0] m_addr;
  logic [8:0] m_wdata, m_count;
  assign m_ready = sel ? s_in_ready : b_in_ready;
  assign m_we    = sel ? s_we : b_we;
  assign m_hold  = sel ? s_hold : b_hold;
  assign m_done  = sel ? s_done : b_done;
  assign m_err   = sel ? s_err : b_err;
  assign m_addr  = sel ? 8'(s_addr) : b_addr;
  assign m_wdata = sel ? s_wdata : b_wdata;
  assign m_count = sel ? 9'(s_count) : b_count;

  prog_loader #(.IW(9), .AW(8)) u_dut (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_valid), .in_data(in_data),
    .in_ready(b_in_ready), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .core_hold(b_hold), .done(b_done), .err(b_err), .count(b_count)
  );

  prog_loader #(.IW(9), .AW(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .in_valid(s_valid), .in_data(in_data),
    .in_ready(s_in_ready), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .core_hold(s_hold), .done(s_done), .err(s_err), .count(s_count)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard: {addr, word} of every write
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int          ready_in_wr = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always @(negedge clk) begin
    if (m_we) got_q.push_back({m_addr, m_wdata});
    if (m_we && m_ready) ready_in_wr++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (m_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("byte_accept_bound", 32'(n < 50), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(m_done === 1'b1 || m_err === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    check("finish_bound", 32'(n < 100), 32'd1);
  endtask

  task automatic exp_word(input logic [7:0] a, input logic [8:0] w);
    exp_q.push_back({a, w});
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
    exp_q.delete();
    got_q.delete();
  endtask

  int c0;

  initial begin
    sel = 1'b0; reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2;
    check("rst_in_ready", 32'(b_in_ready), 32'd0);
    check("rst_we", 32'(b_we), 32'd0);
    check("rst_addr", 32'(b_addr), 32'd0);
    check("rst_wdata", 32'(b_wdata), 32'd0);
    check("rst_hold", 32'(b_hold), 32'd1);
    check("rst_done", 32'(b_done), 32'd0);
    check("rst_err", 32'(b_err), 32'd0);
    check("rst_count", 32'(b_count), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(m_ready), 32'd0);

    // N=2: 1A5, 0F3 with no stalls, 7 cycles HDR -> DONE
    do_start();
    check("hdr_ready", 32'(m_ready), 32'd1);
    c0 = cyc;
    send_byte(8'h02, 0); send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'hF3, 0); send_byte(8'h00, 0);
    wait_end();
    check("n2_cycles", 32'(cyc - c0), 32'd7);
    check("n2_done", 32'(m_done), 32'd1);
    check("n2_hold", 32'(m_hold), 32'd0);
    check("n2_count", 32'(m_count), 32'd2);
    exp_word(8'd0, 9'h1A5); exp_word(8'd1, 9'h0F3);
    cmp_writes("n2");

    // start with a byte already valid in DONE: header taken the cycle after
    in_valid = 1'b1; in_data = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done_drop", 32'(m_done), 32'd0);
    check("restart_count", 32'(m_count), 32'd0);
    check("restart_ready", 32'(m_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    send_byte(8'h55, 0); send_byte(8'h01, 0);
    wait_end();
    check("restart_done", 32'(m_done), 32'd1);
    check("restart_count_end", 32'(m_count), 32'd1);
    exp_word(8'd0, 9'h155);
    cmp_writes("restart");

    // header 00 -> ERR
    do_start();
    send_byte(8'h00, 0);
    check("h0_err", 32'(m_err), 32'd1);
    check("h0_hold", 32'(m_hold), 32'd1);
    check("h0_count", 32'(m_count), 32'd0);
    tick();
    check("h0_err_hold", 32'(m_err), 32'd1);
    cmp_writes("h0");

    // bad high byte -> ERR with no write, then recovery
    do_start();
    check("bad_err_clear", 32'(m_err), 32'd0);
    send_byte(8'h01, 0); send_byte(8'h34, 0); send_byte(8'h02, 0);
    check("bad_err", 32'(m_err), 32'd1);
    check("bad_count", 32'(m_count), 32'd0);
    tick();
    cmp_writes("bad");
    do_start();
    send_byte(8'h01, 0); send_byte(8'h3C, 0); send_byte(8'h00, 0);
    wait_end();
    check("recover_done", 32'(m_done), 32'd1);
    check("recover_err", 32'(m_err), 32'd0);
    exp_word(8'd0, 9'h03C);
    cmp_writes("recover");

    // N=4 with random in_valid gaps; start mid-load must be ignored
    do_start();
    send_byte(8'h04, $urandom_range(0, 3));
    send_byte(8'h00, $urandom_range(0, 3)); send_byte(8'h00, $urandom_range(0, 3));
    start = 1'b1;
    send_byte(8'hFF, $urandom_range(0, 3));
    start = 1'b0;
    send_byte(8'h01, $urandom_range(0, 3));
    send_byte(8'h80, $urandom_range(0, 3)); send_byte(8'h00, $urandom_range(0, 3));
    send_byte(8'h01, $urandom_range(0, 3)); send_byte(8'h01, $urandom_range(0, 3));
    wait_end();
    check("gap_done", 32'(m_done), 32'd1);
    check("gap_count", 32'(m_count), 32'd4);
    exp_word(8'd0, 9'h000); exp_word(8'd1, 9'h1FF);
    exp_word(8'd2, 9'h080); exp_word(8'd3, 9'h101);
    cmp_writes("gap");

    // reset while in HI of word 3
    do_start();
    send_byte(8'h04, 0);
    send_byte(8'h10, 0); send_byte(8'h00, 0);
    send_byte(8'h20, 0); send_byte(8'h01, 0);
    send_byte(8'h30, 0);
    check("mid_in_hi_ready", 32'(m_ready), 32'd1);
    check("mid_count", 32'(m_count), 32'd2);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(b_in_ready), 32'd0);
    check("mid_rst_we", 32'(b_we), 32'd0);
    check("mid_rst_addr", 32'(b_addr), 32'd0);
    check("mid_rst_wdata", 32'(b_wdata), 32'd0);
    check("mid_rst_hold", 32'(b_hold), 32'd1);
    check("mid_rst_done", 32'(b_done), 32'd0);
    check("mid_rst_err", 32'(b_err), 32'd0);
    check("mid_rst_count", 32'(b_count), 32'd0);
    tick();
    reset = 1'b0;
    exp_word(8'd0, 9'h010); exp_word(8'd1, 9'h120);
    cmp_writes("mid_pre");
    tick();
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h00, 0);
    send_byte(8'h22, 0); send_byte(8'h01, 0);
    wait_end();
    check("reload_count", 32'(m_count), 32'd2);
    exp_word(8'd0, 9'h011); exp_word(8'd1, 9'h122);
    cmp_writes("reload");

    // AW=2 build: DEPTH=4
    sel = 1'b1;
    tick();
    do_start();
    send_byte(8'h05, 0);
    check("small_h5_err", 32'(m_err), 32'd1);
    check("small_h5_count", 32'(m_count), 32'd0);
    do_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h02, $urandom_range(0, 2)); send_byte(8'h01, 0);
    send_byte(8'hC3, 0); send_byte(8'h00, $urandom_range(0, 2));
    send_byte(8'hFE, 0); send_byte(8'h01, 0);
    wait_end();
    check("small_done", 32'(m_done), 32'd1);
    check("small_count", 32'(m_count), 32'd4);
    exp_word(8'd0, 9'h001); exp_word(8'd1, 9'h102);
    exp_word(8'd2, 9'h0C3); exp_word(8'd3, 9'h1FE);
    cmp_writes("small");

    check("ready_in_wr", 32'(ready_in_wr), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
